i2c_reg_bridge: RTL and testbench

//  Sits directly downstream of i2c_target: turns its byte stream and transaction

---
 rtl/i2c_reg_bridge_if.sv | 30 +++
 rtl/i2c_reg_bridge.sv | 137 +++++++++++++
 tb/tb_i2c_reg_bridge.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_bridge_if.sv
// Register-bus bundle between the I2C bridge (master) and a register file (slave).
// Requests are level-held until ack; rdata is valid in the ack cycle.
interface i2c_reg_bridge_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic              we;
  logic              re;
  logic [7:0]        rdata;
  logic              ack;

  modport master (
    output addr,
    output wdata,
    output we,
    output re,
    input  rdata,
    input  ack
  );

  modport slave (
    input  addr,
    input  wdata,
    input  we,
    input  re,
    output rdata,
    output ack
  );
endinterface

// File: rtl/i2c_reg_bridge.sv
// Bridges the i2c_target byte/event stream onto an 8-bit register bus
// with an auto-incrementing register pointer.
module i2c_reg_bridge #(
  parameter int ADDR_W      = 4,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i2c_rx_byte_data_i,
  input  logic             i2c_rx_byte_valid_i,
  input  logic             i2c_transaction_start_i,
  input  logic             i2c_transaction_stop_i,
  input  logic             i2c_tx_byte_req_i,
  output logic [7:0]       i2c_tx_byte_data_o,
  output logic             i2c_tx_byte_valid_o,
  output logic             err_overrun_o,
  output logic             err_timeout_o,
  i2c_reg_bridge_if.master bus
);

  localparam int CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WR_BUS,
    S_RD_BUS
  } state_t;

  typedef enum logic [1:0] {
    AFT_NONE,
    AFT_IDLE,
    AFT_ADDR
  } after_t;

  state_t            state;
  after_t            after;
  after_t            nxt_after;
  logic [ADDR_W-1:0] ptr;
  logic [CW-1:0]     cnt;
  logic [7:0]        wdata;
  logic              we;
  logic              re;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              err_ov;
  logic              err_to;
  logic              evt;
  logic              tmo;

  assign evt = i2c_transaction_start_i | i2c_transaction_stop_i;
  assign tmo = (cnt == CW'(BUS_TIMEOUT - 1));

  // Events seen mid-access are remembered; the most recent one wins.
  always_comb begin
    nxt_after = after;
    if (i2c_transaction_stop_i)
      nxt_after = AFT_IDLE;
    else if (i2c_transaction_start_i)
      nxt_after = AFT_ADDR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      after    <= AFT_NONE;
      ptr      <= '0;
      cnt      <= '0;
      wdata    <= '0;
      we       <= 1'b0;
      re       <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      err_ov   <= 1'b0;
      err_to   <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      err_ov   <= 1'b0;
      err_to   <= 1'b0;
      unique case (state)
        S_WR_BUS, S_RD_BUS: begin
          err_ov <= (i2c_rx_byte_valid_i | i2c_tx_byte_req_i) & ~evt;
          if (bus.ack | tmo) begin
            we     <= 1'b0;
            re     <= 1'b0;
            cnt    <= '0;
            ptr    <= ptr + 1'b1;
            err_to <= ~bus.ack;
            after  <= AFT_NONE;
            if (state == S_RD_BUS && nxt_after == AFT_NONE) begin
              tx_valid <= 1'b1;
              tx_data  <= bus.ack ? bus.rdata : 8'hFF;
            end
            unique case (nxt_after)
              AFT_IDLE: state <= S_IDLE;
              AFT_ADDR: state <= S_ADDR;
              default:  state <= S_DATA;
            endcase
          end else begin
            cnt   <= cnt + 1'b1;
            after <= nxt_after;
          end
        end
        default: begin
          if (i2c_transaction_stop_i) begin
            state <= S_IDLE;
          end else if (i2c_transaction_start_i) begin
            state <= S_ADDR;
          end else if (state == S_ADDR && i2c_rx_byte_valid_i) begin
            ptr    <= i2c_rx_byte_data_i[ADDR_W-1:0];
            state  <= S_DATA;
            err_ov <= i2c_tx_byte_req_i;
          end else if (state == S_DATA && i2c_rx_byte_valid_i) begin
            wdata  <= i2c_rx_byte_data_i;
            we     <= 1'b1;
            state  <= S_WR_BUS;
            err_ov <= i2c_tx_byte_req_i;
          end else if (state != S_IDLE && i2c_tx_byte_req_i) begin
            re    <= 1'b1;
            state <= S_RD_BUS;
          end
        end
      endcase
    end
  end

  assign bus.addr            = ptr;
  assign bus.wdata           = wdata;
  assign bus.we              = we;
  assign bus.re              = re;
  assign i2c_tx_byte_data_o  = tx_data;
  assign i2c_tx_byte_valid_o = tx_valid;
  assign err_overrun_o       = err_ov;
  assign err_timeout_o       = err_to;

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// Bench for i2c_reg_bridge: directed scenarios with literal expectations,
// then random traffic checked cycle by cycle against a transaction model.
module tb_i2c_reg_bridge;

  localparam int AW = 4;
  localparam int BT = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       err_ov;
  logic       err_to;

  i2c_reg_bridge_if #(.ADDR_W(AW)) bus ();

  i2c_reg_bridge #(.ADDR_W(AW), .BUS_TIMEOUT(BT)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .i2c_rx_byte_data_i      (rx_data),
    .i2c_rx_byte_valid_i     (rx_valid),
    .i2c_transaction_start_i (start),
    .i2c_transaction_stop_i  (stop),
    .i2c_tx_byte_req_i       (tx_req),
    .i2c_tx_byte_data_o      (tx_data),
    .i2c_tx_byte_valid_o     (tx_valid),
    .err_overrun_o           (err_ov),
    .err_timeout_o           (err_to),
    .bus                     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file on the bus side with configurable ack latency.
  logic [7:0] tb_mem [16];
  int  fixed_lat = 2;
  bit  hold_ack = 1'b0;
  int  age_r = 0;
  int  lat = 0;

  initial begin
    bus.ack = 1'b0;
    bus.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !(bus.we || bus.re)) begin
        age_r = 0;
        bus.ack = 1'b0;
      end else begin
        if (age_r == 0) begin
          if (fixed_lat >= 0)
            lat = fixed_lat;
          else if ($urandom_range(0, 9) == 0)
            lat = 1000;
          else
            lat = $urandom_range(0, 3);
        end
        bus.ack = !hold_ack && (age_r >= lat);
        age_r++;
      end
      bus.rdata = tb_mem[bus.addr];
    end
  end

  always @(posedge clk)
    if (bus.ack && bus.we)
      tb_mem[bus.addr] <= bus.wdata;

  // Transaction-level model: phase 0 outside a transaction, 1 awaiting
  // the pointer byte, 2 streaming data; one bus access in flight at most.
  logic [7:0]    m_mem [16];
  int            m_phase = 0;
  bit            m_busy = 0;
  bit            m_rd = 0;
  int            m_age = 0;
  int            m_after = -1;
  logic [AW-1:0] m_ptr = '0;
  logic [7:0]    m_wd = '0;
  logic [7:0]    e_txd = '0;
  bit            e_txv = 0;
  bit            e_ov = 0;
  bit            e_to = 0;
  bit            mon_on = 0;

  always @(posedge clk) begin
    mon_on = 1'b1;
    e_txv = 0;
    e_ov = 0;
    e_to = 0;
    if (rst) begin
      m_phase = 0;
      m_busy = 0;
      m_ptr = '0;
      m_wd = '0;
      e_txd = '0;
    end else if (m_busy) begin
      if (stop) m_after = 0;
      else if (start) m_after = 1;
      e_ov = (rx_valid || tx_req) && !(start || stop);
      m_age++;
      if (bus.ack || m_age >= BT) begin
        if (bus.ack && !m_rd) m_mem[m_ptr] = m_wd;
        if (m_rd && m_after < 0) begin
          e_txv = 1;
          e_txd = bus.ack ? m_mem[m_ptr] : 8'hFF;
        end
        e_to = !bus.ack;
        m_ptr = m_ptr + 1'b1;
        m_busy = 0;
        m_phase = (m_after < 0) ? 2 : m_after;
      end
    end else if (stop) begin
      m_phase = 0;
    end else if (start) begin
      m_phase = 1;
    end else if (m_phase == 1 && rx_valid) begin
      m_ptr = rx_data[AW-1:0];
      m_phase = 2;
      e_ov = tx_req;
    end else if (m_phase == 2 && rx_valid) begin
      m_wd = rx_data;
      m_busy = 1;
      m_rd = 0;
      m_age = 0;
      m_after = -1;
      e_ov = tx_req;
    end else if (m_phase != 0 && tx_req) begin
      m_busy = 1;
      m_rd = 1;
      m_age = 0;
      m_after = -1;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("we", bus.we, m_busy && !m_rd);
      chk("re", bus.re, m_busy && m_rd);
      chk("addr", bus.addr, m_ptr);
      chk("wdata", bus.wdata, m_wd);
      chk("tx_valid", tx_valid, e_txv);
      chk("tx_data", tx_data, e_txd);
      chk("err_overrun", err_ov, e_ov);
      chk("err_timeout", err_to, e_to);
    end
  end

  task automatic cyc(input bit st, input bit sp, input bit rv,
                     input logic [7:0] d, input bit tq);
    @(posedge clk);
    #1;
    start = st;
    stop = sp;
    rx_valid = rv;
    rx_data = d;
    tx_req = tq;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 0);
  endtask

  bit   seen;
  int   hit_at;
  logic [7:0] got;

  initial begin
    for (int i = 0; i < 16; i++) begin
      tb_mem[i] = 8'h57 + 8'(i);
      m_mem[i] = 8'h57 + 8'(i);
    end
    idle(3);
    chk("rst_addr", bus.addr, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_txd", tx_data, 0);
    rst = 1'b0;
    idle(2);

    // write 0xA5 to register 3
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h03, 0);
    cyc(0, 0, 1, 8'hA5, 0);
    idle(1);
    chk("t1_we", bus.we, 1);
    chk("t1_addr", bus.addr, 3);
    chk("t1_wdata", bus.wdata, 8'hA5);
    idle(4);
    chk("t1_ptr", bus.addr, 4);
    chk("t1_mem", tb_mem[3], 8'hA5);

    // pointer wrap 0xF -> 0x0
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h0F, 0);
    cyc(0, 0, 1, 8'h11, 0);
    idle(5);
    cyc(0, 0, 1, 8'h22, 0);
    idle(5);
    cyc(0, 1, 0, 8'h00, 0);
    idle(1);
    chk("t2_memF", tb_mem[15], 8'h11);
    chk("t2_mem0", tb_mem[0], 8'h22);
    chk("t2_ptr", bus.addr, 1);

    // set pointer, repeated start, read
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h05, 0);
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 0, 0, 8'h00, 1);
    idle(1);
    chk("t3_re", bus.re, 1);
    chk("t3_addr", bus.addr, 5);
    seen = 0;
    got = '0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (tx_valid) begin
        seen = 1;
        got = tx_data;
      end
    end
    chk("t3_txv", seen, 1);
    chk("t3_txd", got, 8'h5C);
    chk("t3_ptr", bus.addr, 6);
    cyc(0, 1, 0, 8'h00, 0);

    // overrun while a write is pending
    fixed_lat = 0;
    hold_ack = 1;
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h06, 0);
    cyc(0, 0, 1, 8'hAA, 0);
    idle(1);
    cyc(0, 0, 1, 8'hBB, 0);
    idle(1);
    chk("t4_overrun", err_ov, 1);
    hold_ack = 0;
    idle(4);
    cyc(0, 1, 0, 8'h00, 0);
    idle(1);
    chk("t4_mem6", tb_mem[6], 8'hAA);
    chk("t4_mem7", tb_mem[7], 8'h5E);
    chk("t4_ptr", bus.addr, 7);

    // read timeout
    hold_ack = 1;
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 0, 0, 8'h00, 1);
    hit_at = -1;
    got = '0;
    seen = 0;
    for (int j = 1; j <= BT + 4; j++) begin
      idle(1);
      if (err_to && hit_at < 0) begin
        hit_at = j;
        seen = tx_valid;
        got = tx_data;
      end
    end
    chk("t5_to_cycle", hit_at, BT + 1);
    chk("t5_txv", seen, 1);
    chk("t5_txd", got, 8'hFF);
    chk("t5_ptr", bus.addr, 8);

    // stop during a read discards the data
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 0, 0, 8'h00, 1);
    idle(1);
    cyc(0, 1, 0, 8'h00, 0);
    idle(1);
    hold_ack = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (tx_valid) seen = 1;
    end
    chk("t6_no_txv", seen, 0);
    chk("t6_ptr", bus.addr, 9);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 8'h33, 0);
      idle(1);
      if (bus.we) seen = 1;
    end
    chk("t6_ignored", seen, 0);
    chk("t6_mem9", tb_mem[9], 8'h60);

    // random traffic
    fixed_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 0;
        stop = 0;
        rx_valid = 0;
        tx_req = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      cyc($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 25, 8'($urandom), $urandom_range(0, 99) < 15);
    end
    idle(BT + 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
